// File: rtl/phase_sequencer.sv
// Phase sequencer for the multi-cycle MIPS CPU.
// Steps a one-hot phase vector p0..p4 once per cycle. Each instruction
// ends on the last phase it needs: p2 for branches, p3 for stores and p4
// for everything else. The vector holds while memory stalls, and the
// sequencer halts on an unsupported instruction. It also counts active
// cycles and retired instructions.
module phase_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             stall,
  input  logic [5:0]       op,
  input  logic [5:0]       irfunc,
  output logic [4:0]       p,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  // Consecutive encoding of P0..P4 lets "next phase" be state + 1.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P0   = 3'd1,
    S_P1   = 3'd2,
    S_P2   = 3'd3,
    S_P3   = 3'd4,
    S_P4   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  state_t state, state_nxt;
  state_t last_phase;
  logic   legal;
  logic   active;
  logic   adv;
  logic   set_illegal;

  // Map a state to its one-hot phase vector. IDLE and HALT drive all zeros.
  function automatic logic [4:0] phase_vec(input state_t s);
    case (s)
      S_P0:    phase_vec = 5'b00001;
      S_P1:    phase_vec = 5'b00010;
      S_P2:    phase_vec = 5'b00100;
      S_P3:    phase_vec = 5'b01000;
      S_P4:    phase_vec = 5'b10000;
      default: phase_vec = 5'b00000;
    endcase
  endfunction

  // Decode the IR to find whether the instruction is supported and
  // which phase it finishes on.
  always_comb begin
    // NOTE: assign every always_comb output a default first. Otherwise a
    // path that never assigns it makes the tool infer a latch.
    legal      = 1'b0;
    last_phase = S_P4;
    case (op)
      6'h00: begin
        case (irfunc)
          6'h08, 6'h09,                              // jr, jalr
          6'h20, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A:  // add, and, or, xor, nor, slt
            legal = 1'b1;
          default: legal = 1'b0;
        endcase
      end
      6'h04, 6'h05: begin                            // beq, bne
        legal      = 1'b1;
        last_phase = S_P2;
      end
      6'h2B: begin                                   // sw
        legal      = 1'b1;
        last_phase = S_P3;
      end
      6'h23, 6'h02, 6'h03,                           // lw, j, jal
      6'h09, 6'h0C, 6'h0D, 6'h0E:                    // addiu, andi, ori, xori
        legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  assign active = (state != S_IDLE) && (state != S_HALT);
  assign adv    = active && !stall;

  // Next-state logic. It also produces the retire pulse and the
  // illegal-instruction trap.
  always_comb begin
    state_nxt   = state;
    instr_done  = 1'b0;
    set_illegal = 1'b0;
    case (state)
      S_IDLE: if (run) state_nxt = S_P0;
      S_P0:   if (adv) state_nxt = S_P1;
      S_P1, S_P2, S_P3, S_P4: begin
        if (adv) begin
          if ((state == S_P1) && !legal) begin
            set_illegal = 1'b1;
            state_nxt   = S_HALT;
          end else if (state == last_phase) begin
            instr_done = 1'b1;
            state_nxt  = run ? S_P0 : S_IDLE;
          end else begin
            state_nxt = state_t'(state + 3'd1);
          end
        end
      end
      default: state_nxt = S_HALT;
    endcase
  end

  // State register. The phase vector is registered beside it, so p never
  // glitches and never has more than one bit set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      p     <= 5'b00000;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. Every flop
      // then samples its pre-edge value, so there are no ordering races.
      state <= state_nxt;
      p     <= phase_vec(state_nxt);
    end
  end

  // The illegal flag is sticky. Only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           illegal <= 1'b0;
    else if (set_illegal) illegal <= 1'b1;
  end

  // Activity counters. They wrap silently modulo 2^CNT_W.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (active)     cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (instr_done) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

endmodule
